// File: rtl/etx_burst_arbiter.sv
// elink TX scheduler: arbitrates rr/rd/wr FIFOs onto one registered
// emesh stream and marks consecutive doubleword writes as a burst.
module etx_burst_arbiter #(
  parameter int          PW       = 104,
  parameter int          MAXBURST = 16,
  parameter logic [11:0] ID       = 12'h999
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          txrr_access,
  input  logic [PW-1:0] txrr_packet,
  output logic          txrr_wait,
  input  logic          txrd_access,
  input  logic [PW-1:0] txrd_packet,
  output logic          txrd_wait,
  input  logic          txwr_access,
  input  logic [PW-1:0] txwr_packet,
  output logic          txwr_wait,
  input  logic          tx_rd_wait,
  input  logic          tx_wr_wait,
  input  logic          etx_wait,
  output logic          etx_access,
  output logic [PW-1:0] etx_packet,
  output logic          etx_burst
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam int CW = 9;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   last_addr;
  logic [4:0]    last_ctrl;

  logic          advance;
  logic          rr_el, rd_el, wr_el;
  logic          gnt_rr, gnt_rd, gnt_wr;
  logic          burst_beat;
  logic          wr_dbl;
  logic [4:0]    wr_ctrl;
  logic [31:0]   wr_dst;
  logic [32:0]   next_addr;
  logic          cont;
  logic [PW-1:0] sel_pkt;

  assign advance = ~etx_wait;
  // Read responses travel as writes on the link.
  assign rr_el = txrr_access & ~tx_wr_wait;
  assign rd_el = txrd_access & ~tx_rd_wait;
  assign wr_el = txwr_access & ~tx_wr_wait;

  assign wr_dbl  = txwr_packet[0] & (txwr_packet[2:1] == 2'b11);
  assign wr_ctrl = txwr_packet[7:3];
  assign wr_dst  = txwr_packet[39:8];

  // 33-bit sum: a carry out means the address wrapped, which ends a burst.
  assign next_addr = {1'b0, last_addr} + 33'd8;

  assign cont = wr_el & wr_dbl
              & (wr_ctrl == last_ctrl)
              & ~next_addr[32]
              & (wr_dst == next_addr[31:0])
              & (cnt < CW'(MAXBURST));

  // Grant selection and next state; BURST locks out rr/rd.
  always_comb begin
    gnt_rr     = 1'b0;
    gnt_rd     = 1'b0;
    gnt_wr     = 1'b0;
    burst_beat = 1'b0;
    state_nx   = state;
    if (advance) begin
      unique case (state)
        IDLE: begin
          if (rr_el) begin
            gnt_rr = 1'b1;
          end else if (rd_el) begin
            gnt_rd = 1'b1;
          end else if (wr_el) begin
            gnt_wr   = 1'b1;
            state_nx = wr_dbl ? BURST : IDLE;
          end
        end
        BURST: begin
          if (cont) begin
            gnt_wr     = 1'b1;
            burst_beat = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign txrr_wait = ~gnt_rr;
  assign txrd_wait = ~gnt_rd;
  assign txwr_wait = ~gnt_wr;

  // Packet mux for the granted channel.
  always_comb begin
    sel_pkt = txwr_packet;
    unique case (1'b1)
      gnt_rr:  sel_pkt = txrr_packet;
      gnt_rd:  sel_pkt = txrd_packet;
      default: sel_pkt = txwr_packet;
    endcase
  end

  // State register and burst tracking.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_addr <= '0;
      last_ctrl <= '0;
    end else begin
      state <= state_nx;
      if (gnt_wr) begin
        last_addr <= wr_dst;
        last_ctrl <= wr_ctrl;
        cnt       <= burst_beat ? cnt + 1'b1 : CW'(1);
      end
    end
  end

  // Output register; holds while the serializer stalls.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      etx_access <= 1'b0;
      etx_packet <= '0;
      etx_burst  <= 1'b0;
    end else if (advance) begin
      etx_access <= gnt_rr | gnt_rd | gnt_wr;
      etx_burst  <= burst_beat;
      if (gnt_rr | gnt_rd | gnt_wr)
        etx_packet <= sel_pkt;
    end
  end

endmodule

// File: tb/tb_etx_burst_arbiter.sv
// Directed bench for etx_burst_arbiter; expected output beats are
// queued as stimulus is driven and popped one per clock.
module tb_etx_burst_arbiter;

  localparam int PW = 104;

  logic          clk;
  logic          nreset;
  logic          txrr_access, txrd_access, txwr_access;
  logic [PW-1:0] txrr_packet, txrd_packet, txwr_packet;
  logic          txrr_wait, txrd_wait, txwr_wait;
  logic          tx_rd_wait, tx_wr_wait, etx_wait;
  logic          etx_access, etx_burst;
  logic [PW-1:0] etx_packet;

  typedef struct {
    logic          acc;
    logic          bur;
    logic [PW-1:0] pkt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  etx_burst_arbiter #(.PW(PW), .MAXBURST(4)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .txrr_access (txrr_access),
    .txrr_packet (txrr_packet),
    .txrr_wait   (txrr_wait),
    .txrd_access (txrd_access),
    .txrd_packet (txrd_packet),
    .txrd_wait   (txrd_wait),
    .txwr_access (txwr_access),
    .txwr_packet (txwr_packet),
    .txwr_wait   (txwr_wait),
    .tx_rd_wait  (tx_rd_wait),
    .tx_wr_wait  (tx_wr_wait),
    .etx_wait    (etx_wait),
    .etx_access  (etx_access),
    .etx_packet  (etx_packet),
    .etx_burst   (etx_burst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input logic wr,
                                       input logic [1:0] dm,
                                       input logic [4:0] ctrl,
                                       input logic [31:0] dst);
    logic [31:0] data;
    data = dst ^ 32'hA5A5_5A5A;
    return {32'hC0DE_0000 | {27'd0, ctrl}, data, dst, ctrl, dm, wr};
  endfunction

  task automatic chk(input string tag,
                     input logic [PW-1:0] obs,
                     input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [2:0] exp);
    chk(tag, PW'({txrr_wait, txrd_wait, txwr_wait}), PW'(exp));
  endtask

  task automatic push(input logic acc, input logic bur,
                      input logic [PW-1:0] pkt);
    exp_t e;
    e.acc = acc;
    e.bur = bur;
    e.pkt = pkt;
    sbq.push_back(e);
  endtask

  task automatic cyc(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s observed empty-queue expected beat", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".acc"}, PW'(etx_access), PW'(e.acc));
      chk({tag, ".burst"}, PW'(etx_burst), PW'(e.bur));
      if (e.acc)
        chk({tag, ".pkt"}, etx_packet, e.pkt);
    end
  endtask

  task automatic setwr(input logic acc, input logic [1:0] dm,
                       input logic [4:0] ctrl, input logic [31:0] dst);
    txwr_access = acc;
    txwr_packet = mk(1'b1, dm, ctrl, dst);
  endtask

  logic [PW-1:0] p, prev, rpk, dpk;

  initial begin
    nreset      = 1'b0;
    txrr_access = 1'b0;
    txrd_access = 1'b0;
    txwr_access = 1'b0;
    txrr_packet = '0;
    txrd_packet = '0;
    txwr_packet = '0;
    tx_rd_wait  = 1'b0;
    tx_wr_wait  = 1'b0;
    etx_wait    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.acc", PW'(etx_access), '0);
    chk("rst.burst", PW'(etx_burst), '0);
    chk("rst.pkt", etx_packet, '0);
    nreset = 1'b1;

    // rr, rd, wr together: strict priority order
    rpk = mk(1'b1, 2'b10, 5'd1, 32'h0000_0100);
    dpk = mk(1'b0, 2'b10, 5'd2, 32'h0000_0200);
    txrr_access = 1'b1;
    txrr_packet = rpk;
    txrd_access = 1'b1;
    txrd_packet = dpk;
    setwr(1'b1, 2'b10, 5'd0, 32'h0000_0500);
    #1 chkw("prio.rr", 3'b011);
    push(1'b1, 1'b0, rpk);
    cyc("prio1");
    txrr_access = 1'b0;
    #1 chkw("prio.rd", 3'b101);
    push(1'b1, 1'b0, dpk);
    cyc("prio2");
    txrd_access = 1'b0;
    #1 chkw("prio.wr", 3'b110);
    push(1'b1, 1'b0, txwr_packet);
    cyc("prio3");
    txwr_access = 1'b0;
    push(1'b0, 1'b0, '0);
    cyc("prio4");

    // four-beat burst
    for (int i = 0; i < 4; i++) begin
      setwr(1'b1, 2'b11, 5'd0, 32'h1000 + 32'(8 * i));
      push(1'b1, i != 0, txwr_packet);
      cyc("b4");
    end
    txwr_access = 1'b0;
    push(1'b0, 1'b0, '0);
    cyc("b4.exit");
    push(1'b0, 1'b0, '0);
    cyc("b4.idle");

    // MAXBURST=4 splits six beats into 4 + 2
    for (int i = 0; i < 4; i++) begin
      setwr(1'b1, 2'b11, 5'd0, 32'h2000 + 32'(8 * i));
      push(1'b1, i != 0, txwr_packet);
      cyc("mx");
    end
    setwr(1'b1, 2'b11, 5'd0, 32'h2020);
    #1 chkw("mx.full", 3'b111);
    push(1'b0, 1'b0, '0);
    cyc("mx.gap");
    push(1'b1, 1'b0, txwr_packet);
    cyc("mx.5");
    setwr(1'b1, 2'b11, 5'd0, 32'h2028);
    push(1'b1, 1'b1, txwr_packet);
    cyc("mx.6");
    txwr_access = 1'b0;
    push(1'b0, 1'b0, '0);
    cyc("mx.exit");

    // 32-bit address wrap breaks the burst
    setwr(1'b1, 2'b11, 5'd0, 32'hFFFF_FFF0);
    push(1'b1, 1'b0, txwr_packet);
    cyc("wrap1");
    setwr(1'b1, 2'b11, 5'd0, 32'hFFFF_FFF8);
    push(1'b1, 1'b1, txwr_packet);
    cyc("wrap2");
    setwr(1'b1, 2'b11, 5'd0, 32'h0000_0000);
    #1 chkw("wrap.stall", 3'b111);
    push(1'b0, 1'b0, '0);
    cyc("wrap.gap");
    push(1'b1, 1'b0, txwr_packet);
    cyc("wrap3");
    // ctrlmode change ends the burst
    setwr(1'b1, 2'b11, 5'd5, 32'h0000_0008);
    push(1'b0, 1'b0, '0);
    cyc("ctl.gap");
    push(1'b1, 1'b0, txwr_packet);
    cyc("ctl1");
    setwr(1'b1, 2'b11, 5'd5, 32'h0000_0010);
    push(1'b1, 1'b1, txwr_packet);
    cyc("ctl2");
    txwr_access = 1'b0;
    push(1'b0, 1'b0, '0);
    cyc("ctl.exit");

    // serializer stall mid-burst, rd blocked by remote wait
    dpk = mk(1'b0, 2'b10, 5'd3, 32'h0000_0300);
    tx_rd_wait  = 1'b1;
    txrd_access = 1'b1;
    txrd_packet = dpk;
    setwr(1'b1, 2'b11, 5'd0, 32'h3000);
    #1 chkw("st.wr", 3'b110);
    push(1'b1, 1'b0, txwr_packet);
    cyc("st1");
    setwr(1'b1, 2'b11, 5'd0, 32'h3008);
    prev = txwr_packet;
    push(1'b1, 1'b1, prev);
    cyc("st2");
    setwr(1'b1, 2'b11, 5'd0, 32'h3010);
    etx_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chkw("st.hold", 3'b111);
      push(1'b1, 1'b1, prev);
      cyc("st.hold");
    end
    etx_wait = 1'b0;
    push(1'b1, 1'b1, txwr_packet);
    cyc("st3");
    txwr_access = 1'b0;
    push(1'b0, 1'b0, '0);
    cyc("st.exit");
    #1 chkw("st.rdblk", 3'b111);
    push(1'b0, 1'b0, '0);
    cyc("st.idle");
    tx_rd_wait = 1'b0;
    #1 chkw("st.rdgo", 3'b101);
    push(1'b1, 1'b0, dpk);
    cyc("st.rd");
    txrd_access = 1'b0;
    push(1'b0, 1'b0, '0);
    cyc("st.end");

    // asynchronous reset mid-burst
    setwr(1'b1, 2'b11, 5'd0, 32'h4000);
    push(1'b1, 1'b0, txwr_packet);
    cyc("ar1");
    setwr(1'b1, 2'b11, 5'd0, 32'h4008);
    push(1'b1, 1'b1, txwr_packet);
    cyc("ar2");
    txwr_access = 1'b0;
    #2 nreset = 1'b0;
    #1;
    chk("ar.acc", PW'(etx_access), '0);
    chk("ar.burst", PW'(etx_burst), '0);
    #2 nreset = 1'b1;
    setwr(1'b1, 2'b11, 5'd0, 32'h4010);
    #1 chkw("ar.wr", 3'b110);
    push(1'b1, 1'b0, txwr_packet);
    cyc("ar3");
    setwr(1'b1, 2'b11, 5'd0, 32'h4018);
    push(1'b1, 1'b1, txwr_packet);
    cyc("ar4");
    txwr_access = 1'b0;
    push(1'b0, 1'b0, '0);
    cyc("ar.exit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
